// File: rtl/mhbf_cfg_loader.sv
// Loads a host-written half-band filter configuration image into local RAM and streams it to the
// filter chain controller over the isConfig/ACK/Done handshake. Optional checksum gate: MHBF_CFG_CKSUM_EN.
module mhbf_cfg_loader #(
    parameter int NMHBF_MAX        = 5,
    parameter int COEFF_WIDTH      = 24,
    parameter int FILTER_MAX_ORDER = 32,
    parameter int ADDR_WIDTH       = 8,
    parameter int TIMEOUT_CYC      = 1023
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   Host_Wr_En,
    input  logic [ADDR_WIDTH-1:0]  Host_Wr_Addr,
    input  logic [COEFF_WIDTH-1:0] Host_Wr_Data,
    input  logic                   Host_Start,
    input  logic [COEFF_WIDTH-1:0] Host_Cksum_In,
    output logic                   Busy_Out,
    output logic                   Done_Out,
    output logic                   Err_Out,
    output logic [1:0]             Err_Code_Out,
    output logic                   isConfig_Out,
    output logic [COEFF_WIDTH-1:0] Data_Config_Out,
    input  logic                   isConfigACK_In,
    input  logic                   isConfigDone_In
);

    localparam int CFG_LEN = 1 + (FILTER_MAX_ORDER + 3) * NMHBF_MAX;
    localparam int RAM_AW  = $clog2(CFG_LEN);
    localparam int IDX_W   = $clog2(CFG_LEN + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
`ifdef MHBF_CFG_CKSUM_EN
        ST_CKSUM,
`endif
        ST_REQ,
        ST_STREAM,
        ST_WAIT_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [9:0]             tmr_q, tmr_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [1:0]             code_q, code_d;
    logic                   cfg_q, cfg_d;
    logic [COEFF_WIDTH-1:0] data_q, data_d;
    logic                   ram_we;
    logic [COEFF_WIDTH-1:0] ram_q [CFG_LEN];

`ifdef MHBF_CFG_CKSUM_EN
    logic [COEFF_WIDTH-1:0] sum_q, sum_d, sum_next;
`else
    logic cksum_unused;
    assign cksum_unused = ^Host_Cksum_In;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tmr_d   = tmr_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        code_d  = code_q;
        cfg_d   = cfg_q;
        data_d  = data_q;
        ram_we  = 1'b0;
`ifdef MHBF_CFG_CKSUM_EN
        sum_d    = sum_q;
        sum_next = sum_q + ram_q[RAM_AW'(idx_q)];
`endif
        case (state_q)
            ST_IDLE: begin
                tmr_d = '0;
                // A start wins over a simultaneous host write.
                if (Host_Start) begin
                    busy_d = 1'b1;
                    err_d  = 1'b0;
                    code_d = 2'b00;
                    idx_d  = '0;
`ifdef MHBF_CFG_CKSUM_EN
                    sum_d   = '0;
                    state_d = ST_CKSUM;
`else
                    cfg_d   = 1'b1;
                    data_d  = ram_q[0];
                    state_d = ST_REQ;
`endif
                end else if (Host_Wr_En && (int'(Host_Wr_Addr) < CFG_LEN)) begin
                    ram_we = 1'b1;
                end
            end
`ifdef MHBF_CFG_CKSUM_EN
            ST_CKSUM: begin
                if (idx_q == IDX_W'(CFG_LEN - 1)) begin
                    idx_d = '0;
                    tmr_d = '0;
                    if (sum_next == Host_Cksum_In) begin
                        cfg_d   = 1'b1;
                        data_d  = ram_q[0];
                        state_d = ST_REQ;
                    end else begin
                        busy_d  = 1'b0;
                        err_d   = 1'b1;
                        code_d  = 2'b11;
                        state_d = ST_IDLE;
                    end
                end else begin
                    sum_d = sum_next;
                    idx_d = idx_q + IDX_W'(1);
                end
            end
`endif
            ST_REQ: begin
                if (isConfigACK_In) begin
                    cfg_d   = 1'b0;
                    data_d  = ram_q[1];
                    idx_d   = IDX_W'(1);
                    tmr_d   = '0;
                    state_d = ST_STREAM;
                end else if (tmr_q == 10'(TIMEOUT_CYC)) begin
                    cfg_d   = 1'b0;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                    code_d  = 2'b01;
                    data_d  = '0;
                    tmr_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_q + 10'd1;
                end
            end
            ST_STREAM: begin
                // The timer measures consecutive stalled cycles, so it restarts on every accepted word.
                if (isConfigACK_In) begin
                    tmr_d = '0;
                    if (idx_q == IDX_W'(CFG_LEN - 1)) begin
                        data_d  = '0;
                        idx_d   = IDX_W'(CFG_LEN);
                        state_d = ST_WAIT_DONE;
                    end else begin
                        data_d = ram_q[RAM_AW'(idx_q + IDX_W'(1))];
                        idx_d  = idx_q + IDX_W'(1);
                    end
                end else if (tmr_q == 10'(TIMEOUT_CYC)) begin
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                    code_d  = 2'b01;
                    data_d  = '0;
                    tmr_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_q + 10'd1;
                end
            end
            ST_WAIT_DONE: begin
                if (isConfigDone_In) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    tmr_d   = '0;
                    state_d = ST_IDLE;
                end else if (tmr_q == 10'(TIMEOUT_CYC)) begin
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                    code_d  = 2'b10;
                    tmr_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_q + 10'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            tmr_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
            cfg_q   <= 1'b0;
            data_q  <= '0;
`ifdef MHBF_CFG_CKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmr_q   <= tmr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
            cfg_q   <= cfg_d;
            data_q  <= data_d;
`ifdef MHBF_CFG_CKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    // Image RAM keeps its contents through reset.
    always_ff @(posedge CLK) begin
        if (ram_we && nRST) begin
            ram_q[RAM_AW'(Host_Wr_Addr)] <= Host_Wr_Data;
        end
    end

    assign Busy_Out        = busy_q;
    assign Done_Out        = done_q;
    assign Err_Out         = err_q;
    assign Err_Code_Out    = code_q;
    assign isConfig_Out    = cfg_q;
    assign Data_Config_Out = data_q;

endmodule
